// File: rtl/rho_pkg.sv
// Shared types and constants for the Keccak rho slice-stream stage.
// Provides slice width, default lane length, FSM states and rotation offsets.
package rho_pkg;

  localparam int SW   = 25;
  localparam int LANE = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EMIT,
    DONE
  } rho_state_t;

  // Rotation offset per lane, indexed by i = 5*y + x.
  localparam int RHO_OFF [SW] = '{
     0,  1, 62, 28, 27,
    36, 44,  6, 55, 20,
     3, 10, 43, 25, 39,
    41, 45, 15, 21,  8,
    18,  2, 61, 56, 14
  };

  // Source slice feeding bit i of output slice z.
  function automatic int unsigned rho_src(
    input int unsigned z,
    input int unsigned i,
    input int unsigned lane = LANE
  );
    int unsigned off;
    off = RHO_OFF[i] % lane;
    return (z + lane - off) % lane;
  endfunction

endpackage

// File: rtl/rho_slice_gather.sv
// Combinational gather of one rotated slice from the buffered state.
// Ports: mem (LANE x SW slices), z (output slice index), slice (rotated slice).
module rho_slice_gather
  import rho_pkg::*;
#(
  parameter int N  = LANE,
  parameter int CW = $clog2(N)
) (
  input  logic [SW-1:0] mem [N],
  input  logic [CW-1:0] z,
  output logic [SW-1:0] slice
);

  for (genvar i = 0; i < SW; i++) begin : g_bit
    logic [CW-1:0] src;
    always_comb begin
      src      = CW'(rho_src(32'(z), i, N));
      slice[i] = mem[src][i];
    end
  end

endmodule

// File: rtl/rho_rotate.sv
// Keccak rho stage: buffers LANE input slices, then streams LANE rotated slices.
// Ports: clk, rst, start, in, read, ready, out, totalReady.
module rho_rotate
  import rho_pkg::*;
#(
  parameter int N = LANE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [SW-1:0] in,
  output logic          read,
  output logic          ready,
  output logic [SW-1:0] out,
  output logic          totalReady
);

  localparam int CW = $clog2(N);

  rho_state_t    state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] mem [N];
  logic [SW-1:0] slice;
  logic          last;

  assign last = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      read       <= 1'b0;
      ready      <= 1'b0;
      totalReady <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            read  <= 1'b1;
          end
        end
        LOAD: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= EMIT;
            read  <= 1'b0;
            ready <= 1'b1;
          end
        end
        EMIT: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state      <= DONE;
            ready      <= 1'b0;
            totalReady <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          totalReady <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer has no reset; contents are always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (state == LOAD) mem[cnt] <= in;
  end

  rho_slice_gather #(
    .N (N)
  ) u_gather (
    .mem   (mem),
    .z     (cnt),
    .slice (slice)
  );

  assign out = ready ? slice : '0;

endmodule
